// File: rtl/fwd_hazard_unit_if.sv
// Bus interface for fwd_hazard_unit.
// Groups every signal except clk/rst:
//   stall_i, flush_i         pipeline freeze / squash of the instruction leaving EX
//   ex_valid_i, ex_rd_i,
//   ex_we_i, ex_is_load_i    description of the instruction currently in EX
//   src_addr_i, src_used_i   per-consumer source register and "actually read" flag
//   fwd_sel_o                per-consumer select: 0 = stay, k = forward from stage k
//   load_use_stall_o         freeze IF/ID/EX and insert a bubble
//   perf_fwd_cnt_o,
//   perf_lu_stall_cnt_o      only present when FWD_HAZARD_STATS_EN is defined
// master: the pipeline side driving requests; slave: the hazard unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned NUM_SRC    = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_ADDR_W = 5
);
  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

  logic                          stall_i;
  logic                          flush_i;
  logic                          ex_valid_i;
  logic [REG_ADDR_W-1:0]         ex_rd_i;
  logic                          ex_we_i;
  logic                          ex_is_load_i;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i;
  logic [NUM_SRC-1:0]            src_used_i;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o;
  logic                          load_use_stall_o;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]                   perf_fwd_cnt_o;
  logic [31:0]                   perf_lu_stall_cnt_o;

  modport master (
    output stall_i, flush_i, ex_valid_i, ex_rd_i, ex_we_i, ex_is_load_i,
           src_addr_i, src_used_i,
    input  fwd_sel_o, load_use_stall_o, perf_fwd_cnt_o, perf_lu_stall_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, ex_valid_i, ex_rd_i, ex_we_i, ex_is_load_i,
           src_addr_i, src_used_i,
    output fwd_sel_o, load_use_stall_o, perf_fwd_cnt_o, perf_lu_stall_cnt_o
  );
`else
  modport master (
    output stall_i, flush_i, ex_valid_i, ex_rd_i, ex_we_i, ex_is_load_i,
           src_addr_i, src_used_i,
    input  fwd_sel_o, load_use_stall_o
  );

  modport slave (
    input  stall_i, flush_i, ex_valid_i, ex_rd_i, ex_we_i, ex_is_load_i,
           src_addr_i, src_used_i,
    output fwd_sel_o, load_use_stall_o
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// Parametrised forwarding / load-use hazard unit for the RV32I pipeline.
// A shift-register scoreboard tracks the NUM_STAGES producer instructions
// older than EX (stage 1 = EX/MEM, stage 2 = MEM/WB, ...). Each consumer gets
// a forward select pointing at the youngest matching producer; a load sitting
// in stage 1 that a consumer needs raises a one-cycle stall and a bubble.
// Ports:
//   clk   core clock
//   rst   asynchronous active-low reset, clears the scoreboard
//   bus   fwd_hazard_unit_if.slave (see interface header for signal list)
// Optional feature: define FWD_HAZARD_STATS_EN to add saturating 32-bit
// counters of forwarding cycles and load-use stall cycles.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC    = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_unit_if.slave   bus
);

  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } sb_entry_t;

  // Scoreboard: r_sb[1] is the youngest producer, r_sb[NUM_STAGES] the oldest
  sb_entry_t r_sb [1:NUM_STAGES];

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_lu_stall;
  logic                     w_fwd_any;
  logic                     w_issue_bubble;

  // True when producer stage k writes the register consumer i reads (never x0)
  function automatic logic hit(input int k, input int i);
    logic [REG_ADDR_W-1:0] src;
    src = bus.src_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
    return r_sb[k].valid && r_sb[k].we && (r_sb[k].rd != '0) &&
           (r_sb[k].rd == src) && bus.src_used_i[i];
  endfunction

  // Select resolution: scan oldest to youngest so the youngest match wins;
  // a consumer that needs a load still in stage 1 stays at 0 and stalls.
  always_comb begin
    w_fwd_sel  = '0;
    w_lu_stall = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = int'(NUM_STAGES); k >= 1; k--) begin
        if (hit(k, i)) begin
          w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
      if (hit(1, i) && r_sb[1].is_load) begin
        w_fwd_sel[i*SEL_W +: SEL_W] = '0;
        w_lu_stall                  = 1'b1;
      end
    end
  end

  assign w_fwd_any      = |w_fwd_sel;
  assign w_issue_bubble = bus.flush_i | w_lu_stall | ~bus.ex_valid_i;

  assign bus.fwd_sel_o        = w_fwd_sel;
  assign bus.load_use_stall_o = w_lu_stall;

  // Scoreboard shift; a global freeze holds everything (flush ignored)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= int'(NUM_STAGES); k++) begin
        r_sb[k] <= '0;
      end
    end else if (!bus.stall_i) begin
      for (int k = int'(NUM_STAGES); k >= 2; k--) begin
        r_sb[k] <= r_sb[k-1];
      end
      if (w_issue_bubble) begin
        r_sb[1] <= '0;
      end else begin
        r_sb[1] <= '{valid:   1'b1,
                     rd:      bus.ex_rd_i,
                     we:      bus.ex_we_i,
                     is_load: bus.ex_is_load_i};
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] r_perf_fwd_cnt;
  logic [31:0] r_perf_lu_stall_cnt;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fwd_cnt      <= '0;
      r_perf_lu_stall_cnt <= '0;
    end else begin
      if (!bus.stall_i && !w_lu_stall && w_fwd_any && (r_perf_fwd_cnt != '1)) begin
        r_perf_fwd_cnt <= r_perf_fwd_cnt + 32'd1;
      end
      if (!bus.stall_i && w_lu_stall && (r_perf_lu_stall_cnt != '1)) begin
        r_perf_lu_stall_cnt <= r_perf_lu_stall_cnt + 32'd1;
      end
    end
  end

  assign bus.perf_fwd_cnt_o      = r_perf_fwd_cnt;
  assign bus.perf_lu_stall_cnt_o = r_perf_lu_stall_cnt;
`else
  logic w_unused;
  assign w_unused = w_fwd_any;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined RV32I core; it replaces the fixed five forwarding muxes with their hard-coded stay/forward1-3 encodings.
- Keeps a shift-register scoreboard of NUM_STAGES in-flight producer instructions older than the consumer (EX) stage.
- Produces one forward select per source operand, priority-resolved to the youngest matching producer.
- Detects load-use hazards, raises a stall, and inserts a bubble into the scoreboard.

Parameters:
NUM_SRC, 5, number of source-operand consumers (alumux1, alumux2, ex_mem rs2, cmpmux1, cmpmux2)
NUM_STAGES, 3, producer stages tracked; stage 1 = EX/MEM, stage 2 = MEM/WB, stage 3 = WB retire
REG_ADDR_W, 5, register index width
SEL_W, $clog2(NUM_STAGES+1), forward select width (derived, not overridable)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
stall_i  in  1  global pipeline freeze (e.g. cache miss)
flush_i  in  1  squash the instruction leaving EX
ex_valid_i  in  1  EX holds a valid instruction
ex_rd_i  in  REG_ADDR_W  destination of the EX instruction
ex_we_i  in  1  EX instruction writes rd
ex_is_load_i  in  1  EX instruction is a load (lb/lbu/lh/lhu/lw)
src_addr_i  in  NUM_SRC*REG_ADDR_W  source register per consumer, packed, consumer 0 in LSBs
src_used_i  in  NUM_SRC  consumer actually reads its source
fwd_sel_o  out  NUM_SRC*SEL_W  per-consumer select: 0 = stay, k = forward from stage k
load_use_stall_o  out  1  freeze IF/ID/EX and insert a bubble

Behaviour:
- Scoreboard entry: {valid, rd, we, is_load}, entries 1..NUM_STAGES. The async reset (rst = 0) clears every valid bit, so fwd_sel_o = 0 and load_use_stall_o = 0 while reset is asserted and after release.
- Match(k, i) = entry k valid & we & rd != 0 & rd == src_addr_i[i] & src_used_i[i].
- fwd_sel_o[i] is the smallest k with Match(k, i), else 0. It is combinational from the scoreboard and inputs, with zero-cycle latency.
- x0 is never forwarded; src = 0 always gives 0.
- load_use_stall_o = OR over i of (Match(1, i) & entry1.is_load). While it is asserted, fwd_sel_o[i] is forced to 0 for every consumer matching a load in stage 1. Other consumers resolve normally.
- Per-clock update, in priority order:
  - stall_i = 1: hold all entries; flush_i is ignored.
  - Otherwise, shift entry k into entry k+1 and drop entry NUM_STAGES.
  - Entry 1 loads a bubble (valid = 0) if flush_i | load_use_stall_o | !ex_valid_i.
  - Else entry 1 loads {1, ex_rd_i, ex_we_i, ex_is_load_i}.
- A load-use stall lasts exactly one cycle. The load moves to stage 2, and the next cycle forwards with sel = 2 and no stall.
- Multiple matches (the same rd in several stages): the youngest stage wins.
- Reset asserted mid-stall clears the scoreboard immediately, so the stall drops asynchronously.
- NUM_STAGES = 1 is legal (SEL_W = 1); a load then stalls once, and the consumer reads the register file afterwards.

Optional Feature:
- Macro FWD_HAZARD_STATS_EN defined: adds outputs perf_fwd_cnt_o[31:0] and perf_lu_stall_cnt_o[31:0].
  - perf_fwd_cnt_o increments each non-stalled cycle in which any fwd_sel_o != 0.
  - perf_lu_stall_cnt_o increments each cycle load_use_stall_o = 1 and stall_i = 0.
  - Both saturate at 32'hFFFFFFFF and reset asynchronously to 0.
- Macro undefined: no counters, no ports, and behaviour is otherwise identical.

Test Plan:
- Back-to-back ALU: EX add x5 (we = 1, not load), next cycle src_addr[0] = 5, used -> fwd_sel[0] = 1. One cycle later -> 2, then 3, then 0.
- Load-use: EX lw x7, next cycle consumer 1 reads x7 -> load_use_stall_o = 1 and fwd_sel[1] = 0 for 1 cycle. The next cycle gives stall = 0 and fwd_sel[1] = 2.
- Priority and x0: x9 written in stages 1 and 3 -> sel = 1. Writer rd = 0 with src = 0 -> sel = 0. Entry with we = 0 matching x9 -> not forwarded.
- Freeze and flush: stall_i = 1 for 4 cycles with flush_i = 1 -> scoreboard and sels unchanged. Then stall_i = 0, flush_i = 1 -> entry 1 becomes a bubble and a consumer of that rd gets sel = 0.
- Async reset mid load-use stall: drop rst between clock edges -> load_use_stall_o and all fwd_sel fall to 0 without a clock edge. After release, with no issue, all stay 0.
- With FWD_HAZARD_STATS_EN: 3 forwarding cycles plus 1 load-use stall -> perf_fwd_cnt_o = 3 and perf_lu_stall_cnt_o = 1. Preloading via force to 32'hFFFFFFFF then holds at that value.
